rs_param: RTL and testbench

- Parametrised successor to the single-CDB reservation station.
- Adds configurable depth, NUM_CDB wakeup broadcast channels, same-cycle dispatch/CDB bypass, oldest-first select with an issue ready/valid handshake, and flush.
- Sits between stage_id (dispatch) and the issue/execute stage; the CDB is driven by the complete stage.

---
 rtl/rs_param.sv | 182 ++++++++++++++++++
 tb/tb_rs_param.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rs_param : reservation station, multi-CDB wakeup, oldest-first issue     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module rs_param #(
  parameter int NUM_ENTRIES = 8,
  parameter int NUM_CDB     = 2,
  parameter int PREG_W      = 6,
  parameter int ROB_W       = 5,
  parameter int OP_W        = 32
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               disp_valid,
  output logic                               disp_ready,
  input  logic [PREG_W-1:0]                  disp_t,
  input  logic [PREG_W-1:0]                  disp_t1,
  input  logic [PREG_W-1:0]                  disp_t2,
  input  logic                               disp_t1_ready,
  input  logic                               disp_t2_ready,
  input  logic [ROB_W-1:0]                   disp_rob_idx,
  input  logic [OP_W-1:0]                    disp_payload,
  input  logic [NUM_CDB-1:0]                 cdb_valid,
  input  logic [NUM_CDB*PREG_W-1:0]          cdb_tag,
  output logic                               issue_valid,
  input  logic                               issue_ready,
  output logic [PREG_W-1:0]                  issue_t,
  output logic [PREG_W-1:0]                  issue_t1,
  output logic [PREG_W-1:0]                  issue_t2,
  output logic [ROB_W-1:0]                   issue_rob_idx,
  output logic [OP_W-1:0]                    issue_payload,
  input  logic                               flush,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]   free_count
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int CNT_W = $clog2(NUM_ENTRIES+1);

  logic              valid_q [NUM_ENTRIES];
  logic              valid_d [NUM_ENTRIES];
  logic [PREG_W-1:0] t_q     [NUM_ENTRIES];
  logic [PREG_W-1:0] t_d     [NUM_ENTRIES];
  logic [PREG_W-1:0] t1_q    [NUM_ENTRIES];
  logic [PREG_W-1:0] t1_d    [NUM_ENTRIES];
  logic [PREG_W-1:0] t2_q    [NUM_ENTRIES];
  logic [PREG_W-1:0] t2_d    [NUM_ENTRIES];
  logic              r1_q    [NUM_ENTRIES];
  logic              r1_d    [NUM_ENTRIES];
  logic              r2_q    [NUM_ENTRIES];
  logic              r2_d    [NUM_ENTRIES];
  logic [ROB_W-1:0]  rob_q   [NUM_ENTRIES];
  logic [ROB_W-1:0]  rob_d   [NUM_ENTRIES];
  logic [OP_W-1:0]   pay_q   [NUM_ENTRIES];
  logic [OP_W-1:0]   pay_d   [NUM_ENTRIES];
  logic [IDX_W-1:0]  age_q   [NUM_ENTRIES];
  logic [IDX_W-1:0]  age_d   [NUM_ENTRIES];
  logic [CNT_W-1:0]  free_count_q;
  logic [CNT_W-1:0]  free_count_d;

  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic [IDX_W-1:0]  sel_age;
  logic [IDX_W-1:0]  free_idx;
  logic              issue_fire;
  logic              disp_fire;
  logic [CNT_W-1:0]  valid_cnt;
  logic [IDX_W-1:0]  disp_age;

  function automatic logic cdb_hit(input logic [NUM_CDB-1:0]        v,
                                   input logic [NUM_CDB*PREG_W-1:0] tags,
                                   input logic [PREG_W-1:0]         tag);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_CDB; k++) begin
      if (v[k] && (tags[k*PREG_W +: PREG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Ages are unique among valid entries, so a strict less-than scan finds the oldest.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (valid_q[i] && r1_q[i] && r2_q[i] && (!sel_found || (age_q[i] < sel_age))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_age   = age_q[i];
      end
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = NUM_ENTRIES-1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  assign disp_ready  = (free_count_q != '0);
  assign issue_valid = sel_found;
  assign issue_fire  = sel_found && issue_ready;
  assign disp_fire   = disp_valid && disp_ready && !flush;
  assign valid_cnt   = CNT_W'(NUM_ENTRIES) - free_count_q;
  assign disp_age    = IDX_W'(valid_cnt - CNT_W'(issue_fire));
  assign free_count  = free_count_q;

  assign issue_t       = sel_found ? t_q[sel_idx]   : '0;
  assign issue_t1      = sel_found ? t1_q[sel_idx]  : '0;
  assign issue_t2      = sel_found ? t2_q[sel_idx]  : '0;
  assign issue_rob_idx = sel_found ? rob_q[sel_idx] : '0;
  assign issue_payload = sel_found ? pay_q[sel_idx] : '0;

  always_comb begin
    valid_d = valid_q;
    t_d     = t_q;
    t1_d    = t1_q;
    t2_d    = t2_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    rob_d   = rob_q;
    pay_d   = pay_q;
    age_d   = age_q;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (valid_q[i]) begin
        if (cdb_hit(cdb_valid, cdb_tag, t1_q[i])) r1_d[i] = 1'b1;
        if (cdb_hit(cdb_valid, cdb_tag, t2_q[i])) r2_d[i] = 1'b1;
        if (issue_fire && (age_q[i] > sel_age)) age_d[i] = age_q[i] - IDX_W'(1);
      end
      if (issue_fire && (IDX_W'(i) == sel_idx)) valid_d[i] = 1'b0;
      if (disp_fire && (IDX_W'(i) == free_idx)) begin
        valid_d[i] = 1'b1;
        t_d[i]     = disp_t;
        t1_d[i]    = disp_t1;
        t2_d[i]    = disp_t2;
        r1_d[i]    = disp_t1_ready | cdb_hit(cdb_valid, cdb_tag, disp_t1);
        r2_d[i]    = disp_t2_ready | cdb_hit(cdb_valid, cdb_tag, disp_t2);
        rob_d[i]   = disp_rob_idx;
        pay_d[i]   = disp_payload;
        age_d[i]   = disp_age;
      end
      if (flush) valid_d[i] = 1'b0;
    end
  end

  always_comb begin
    free_count_d = free_count_q + CNT_W'(issue_fire) - CNT_W'(disp_fire);
    if (flush) free_count_d = CNT_W'(NUM_ENTRIES);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        t_q[i]     <= '0;
        t1_q[i]    <= '0;
        t2_q[i]    <= '0;
        r1_q[i]    <= 1'b0;
        r2_q[i]    <= 1'b0;
        rob_q[i]   <= '0;
        pay_q[i]   <= '0;
        age_q[i]   <= '0;
      end
      free_count_q <= CNT_W'(NUM_ENTRIES);
    end else begin
      valid_q      <= valid_d;
      t_q          <= t_d;
      t1_q         <= t1_d;
      t2_q         <= t2_d;
      r1_q         <= r1_d;
      r2_q         <= r2_d;
      rob_q        <= rob_d;
      pay_q        <= pay_d;
      age_q        <= age_d;
      free_count_q <= free_count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rs_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rs_param : vector table plus issue-order scoreboard for rs_param      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_rs_param;
  localparam int N  = 8;
  localparam int NC = 2;
  localparam int PW = 6;
  localparam int RW = 5;
  localparam int OW = 32;
  localparam int CW = $clog2(N+1);

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          disp_valid, disp_ready;
  logic [PW-1:0] disp_t, disp_t1, disp_t2;
  logic          disp_t1_ready, disp_t2_ready;
  logic [RW-1:0] disp_rob_idx;
  logic [OW-1:0] disp_payload;
  logic [NC-1:0] cdb_valid;
  logic [NC*PW-1:0] cdb_tag;
  logic          issue_valid, issue_ready;
  logic [PW-1:0] issue_t, issue_t1, issue_t2;
  logic [RW-1:0] issue_rob_idx;
  logic [OW-1:0] issue_payload;
  logic          flush;
  logic [CW-1:0] free_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          dv;
    logic [PW-1:0] t, t1, t2;
    logic          r1, r2;
    logic [NC-1:0] cv;
    logic [PW-1:0] c0, c1;
    logic          ir;
    logic          exp_iv;
    logic [CW-1:0] exp_free;
  } vec_t;

  typedef struct {
    logic [PW-1:0] t, t1;
    logic [RW-1:0] rob;
    logic [OW-1:0] pay;
  } sb_t;

  vec_t tbl[11];
  sb_t  sb_q[$];

  rs_param #(.NUM_ENTRIES(N), .NUM_CDB(NC), .PREG_W(PW), .ROB_W(RW), .OP_W(OW)) dut (
    .clock(clock), .reset(reset),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_t(disp_t), .disp_t1(disp_t1), .disp_t2(disp_t2),
    .disp_t1_ready(disp_t1_ready), .disp_t2_ready(disp_t2_ready),
    .disp_rob_idx(disp_rob_idx), .disp_payload(disp_payload),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_t(issue_t), .issue_t1(issue_t1), .issue_t2(issue_t2),
    .issue_rob_idx(issue_rob_idx), .issue_payload(issue_payload),
    .flush(flush), .free_count(free_count)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Handshake is stable from just after one edge until the next, so sample mid-cycle.
  always @(negedge clock) begin
    if (reset && issue_valid && issue_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: issue_t=%0d with nothing expected", issue_t);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        chk("sb_t", 32'(issue_t), 32'(e.t));
        chk("sb_t1", 32'(issue_t1), 32'(e.t1));
        chk("sb_rob", 32'(issue_rob_idx), 32'(e.rob));
        chk("sb_pay", issue_payload, e.pay);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_idle();
    disp_valid = 1'b0; disp_t = '0; disp_t1 = '0; disp_t2 = '0;
    disp_t1_ready = 1'b0; disp_t2_ready = 1'b0;
    disp_rob_idx = '0; disp_payload = '0;
    cdb_valid = '0; cdb_tag = '0; flush = 1'b0;
  endtask

  // Drives a dispatch; rob and payload are derived from the tag so each is distinct.
  task automatic disp(input logic [PW-1:0] t, input logic [PW-1:0] t1, input logic r1,
                      input logic [PW-1:0] t2, input logic r2, input logic expect_issue);
    sb_t e;
    disp_valid = 1'b1; disp_t = t; disp_t1 = t1; disp_t1_ready = r1;
    disp_t2 = t2; disp_t2_ready = r2;
    disp_rob_idx = t[RW-1:0];
    disp_payload = 32'hCAFE_0000 | 32'(t);
    if (expect_issue) begin
      e.t = t; e.t1 = t1; e.rob = t[RW-1:0]; e.pay = 32'hCAFE_0000 | 32'(t);
      sb_q.push_back(e);
    end
  endtask

  function automatic vec_t mk(logic dv, logic [PW-1:0] t, logic [PW-1:0] t1, logic r1,
                              logic [PW-1:0] t2, logic r2, logic [NC-1:0] cv,
                              logic [PW-1:0] c0, logic [PW-1:0] c1, logic ir,
                              logic eiv, logic [CW-1:0] ef);
    vec_t v;
    v.dv = dv; v.t = t; v.t1 = t1; v.r1 = r1; v.t2 = t2; v.r2 = r2;
    v.cv = cv; v.c0 = c0; v.c1 = c1; v.ir = ir; v.exp_iv = eiv; v.exp_free = ef;
    return v;
  endfunction

  initial begin
    set_idle();
    issue_ready = 1'b0;

    tbl[0]  = mk(1, 40, 33, 0,  5, 1, 2'b00,  0,  0, 1, 0, 7);
    tbl[1]  = mk(0,  0,  0, 0,  0, 0, 2'b01, 33,  0, 1, 1, 7);
    tbl[2]  = mk(0,  0,  0, 0,  0, 0, 2'b00,  0,  0, 1, 0, 8);
    tbl[3]  = mk(1, 41, 32, 0,  7, 1, 2'b10,  0, 32, 1, 1, 7);
    tbl[4]  = mk(0,  0,  0, 0,  0, 0, 2'b00,  0,  0, 1, 0, 8);
    tbl[5]  = mk(1, 42,  1, 1,  2, 1, 2'b00,  0,  0, 0, 1, 7);
    tbl[6]  = mk(0,  0,  0, 0,  0, 0, 2'b00,  0,  0, 1, 0, 8);
    tbl[7]  = mk(1, 43, 50, 0, 51, 0, 2'b00,  0,  0, 1, 0, 7);
    tbl[8]  = mk(0,  0,  0, 0,  0, 0, 2'b01, 50, 51, 1, 0, 7);
    tbl[9]  = mk(0,  0,  0, 0,  0, 0, 2'b10,  0, 51, 1, 1, 7);
    tbl[10] = mk(0,  0,  0, 0,  0, 0, 2'b00,  0,  0, 1, 0, 8);

    // Reset state
    #12;
    chk("rst_free", 32'(free_count), 8);
    chk("rst_dr", 32'(disp_ready), 1);
    chk("rst_iv", 32'(issue_valid), 0);
    chk("rst_t", 32'(issue_t), 0);
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_free", 32'(free_count), 8);

    // Single-cycle vectors: wakeup, bypass, direct-ready, per-channel matching
    foreach (tbl[i]) begin
      set_idle();
      if (tbl[i].dv) disp(tbl[i].t, tbl[i].t1, tbl[i].r1, tbl[i].t2, tbl[i].r2, 1'b1);
      cdb_valid = tbl[i].cv;
      cdb_tag = {tbl[i].c1, tbl[i].c0};
      issue_ready = tbl[i].ir;
      tick();
      chk($sformatf("vec%0d_iv", i), 32'(issue_valid), 32'(tbl[i].exp_iv));
      chk($sformatf("vec%0d_free", i), 32'(free_count), 32'(tbl[i].exp_free));
      chk($sformatf("vec%0d_dr", i), 32'(disp_ready), 1);
      if (!tbl[i].exp_iv) chk($sformatf("vec%0d_idle_t", i), 32'(issue_t), 0);
    end

    // Oldest-first, plus a ready dispatch landing in the same cycle as an issue
    set_idle();
    issue_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      disp(PW'(10 + i), 20, 0, 3, 1, 1'b1);
      tick();
    end
    set_idle();
    chk("of_free3", 32'(free_count), 5);
    chk("of_wait_iv", 32'(issue_valid), 0);
    cdb_valid = 2'b01;
    cdb_tag = {6'd0, 6'd20};
    tick();
    set_idle();
    chk("of_wake_iv", 32'(issue_valid), 1);
    chk("of_first_t", 32'(issue_t), 10);
    disp(13, 4, 1, 5, 1, 1'b1);
    tick();
    set_idle();
    chk("of_mid_free", 32'(free_count), 5);
    repeat (3) tick();
    chk("of_drain_q", 32'(sb_q.size()), 0);
    chk("of_drain_free", 32'(free_count), 8);
    chk("of_drain_iv", 32'(issue_valid), 0);

    // Full: eight entries, refused ninth, then issue+dispatch while full
    issue_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      disp(PW'(60 + i), 1, 1, 2, 1, 1'b1);
      tick();
    end
    set_idle();
    chk("full_free", 32'(free_count), 0);
    chk("full_dr", 32'(disp_ready), 0);
    disp(99, 1, 1, 2, 1, 1'b0);
    tick();
    chk("full_ninth_free", 32'(free_count), 0);
    disp(98, 1, 1, 2, 1, 1'b0);
    issue_ready = 1'b1;
    tick();
    set_idle();
    issue_ready = 1'b0;
    chk("full_issue_free", 32'(free_count), 1);
    chk("full_issue_dr", 32'(disp_ready), 1);
    chk("full_next_t", 32'(issue_t), 61);
    flush = 1'b1;
    sb_q.delete();
    tick();
    set_idle();
    chk("full_flush_free", 32'(free_count), 8);

    // Flush with four valid entries and a simultaneous ready dispatch
    for (int i = 0; i < 4; i++) begin
      disp(PW'(70 + i), 30, 0, 2, 1, 1'b0);
      tick();
    end
    set_idle();
    chk("fl_free4", 32'(free_count), 4);
    disp(77, 1, 1, 2, 1, 1'b0);
    flush = 1'b1;
    tick();
    set_idle();
    chk("fl_free", 32'(free_count), 8);
    chk("fl_iv", 32'(issue_valid), 0);
    tick();
    chk("fl_hold_free", 32'(free_count), 8);
    chk("fl_hold_iv", 32'(issue_valid), 0);

    // Asynchronous reset mid-run with three valid entries and dispatch traffic
    for (int i = 0; i < 3; i++) begin
      disp(PW'(80 + i), 31, 0, 2, 1, 1'b0);
      tick();
    end
    set_idle();
    chk("ar_free3", 32'(free_count), 5);
    disp(85, 1, 1, 2, 1, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("ar_free", 32'(free_count), 8);
    chk("ar_dr", 32'(disp_ready), 1);
    chk("ar_iv", 32'(issue_valid), 0);
    tick();
    chk("ar_hold_free", 32'(free_count), 8);
    chk("ar_hold_iv", 32'(issue_valid), 0);
    set_idle();
    reset = 1'b1;
    tick();
    chk("ar_rel_free", 32'(free_count), 8);
    chk("ar_rel_iv", 32'(issue_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
